// File: rtl/bitrec_pkg.sv
// Shared definitions for the bit-recovery path: deserializer state encoding and
// constants common with the clock-recovery stage.
package bitrec_pkg;

  localparam int unsigned PERIOD_LEN = 32;
  localparam logic [7:0]  SYNC_WORD  = 8'hD5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHunt = 2'd1,
    StData = 2'd2
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage; Depth must be a power of two.
// A write while full is accepted only when a read happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q[AddrW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PtrOne;
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_wr) mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/bit_deserializer.sv
// Mid-bit sampler with edge-resynchronised phase, sync-word hunt and MSB-first
// byte assembly, delivering bytes through a small FIFO with valid/ready.
module bit_deserializer #(
  parameter int unsigned PERIOD_LEN = bitrec_pkg::PERIOD_LEN,
  parameter logic [7:0]  SYNC_WORD  = bitrec_pkg::SYNC_WORD,
  parameter int unsigned MIN_PERIOD = 8,
  parameter int unsigned IDLE_BITS  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signal,
  input  logic [PERIOD_LEN-1:0] bit_period,
  input  logic                  period_lock,
  output logic [7:0]            data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_active,
  output logic                  overflow
);

  import bitrec_pkg::*;

  localparam int unsigned IdleW = $clog2(IDLE_BITS + 1);

  logic                  sync1_q, sync2_q, prev_q;
  logic                  line_edge;
  logic [PERIOD_LEN-1:0] phase_q, phase_d;
  logic                  strobe;
  logic [IdleW-1:0]      idle_q, idle_d;
  logic                  idle_hit;
  logic                  go_idle;
  state_e                state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic                  push_q, push_d;
  logic [7:0]            push_byte_q, push_byte_d;
  logic                  frame_active_q;
  logic                  overflow_q, overflow_d;
  logic                  fifo_full, fifo_empty, pop, fifo_wr;

  assign line_edge = sync2_q ^ prev_q;
  assign go_idle   = !period_lock || (bit_period < PERIOD_LEN'(MIN_PERIOD));
  // An edge resets phase, so it also suppresses a coincident strobe.
  assign strobe    = (state_q != StIdle) && !line_edge && (phase_q == (bit_period >> 1));
  assign idle_hit  = (idle_q == IdleW'(IDLE_BITS));

  always_comb begin
    phase_d = phase_q + PERIOD_LEN'(1);
    if (line_edge) begin
      phase_d = '0;
    end else if (phase_q >= bit_period - PERIOD_LEN'(1)) begin
      phase_d = '0;
    end
  end

  always_comb begin
    idle_d = idle_q;
    if (line_edge) begin
      idle_d = '0;
    end else if (strobe && !idle_hit) begin
      idle_d = idle_q + IdleW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    if (go_idle) begin
      state_d   = StIdle;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StHunt;
        StHunt: begin
          if (strobe) begin
            shift_d = {shift_q[6:0], sync2_q};
            if (shift_d == SYNC_WORD) begin
              state_d   = StData;
              bit_cnt_d = '0;
            end
          end
        end
        StData: begin
          if (idle_hit) begin
            state_d   = StHunt;
            shift_d   = '0;
            bit_cnt_d = '0;
          end else if (strobe) begin
            shift_d   = {shift_q[6:0], sync2_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              push_d      = 1'b1;
              push_byte_d = shift_d;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign pop        = data_ready && !fifo_empty;
  assign fifo_wr    = push_q && (!fifo_full || pop);
  assign overflow_d = overflow_q || (push_q && fifo_full && !pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      phase_q        <= '0;
      idle_q         <= '0;
      state_q        <= StIdle;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      push_q         <= 1'b0;
      push_byte_q    <= '0;
      frame_active_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      sync1_q        <= signal;
      sync2_q        <= sync1_q;
      prev_q         <= sync2_q;
      phase_q        <= phase_d;
      idle_q         <= idle_d;
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      push_q         <= push_d;
      push_byte_q    <= push_byte_d;
      frame_active_q <= (state_d == StData);
      overflow_q     <= overflow_d;
    end
  end

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (fifo_wr),
    .wr_data(push_byte_q),
    .full   (fifo_full),
    .rd_en  (pop),
    .rd_data(data),
    .empty  (fifo_empty)
  );

  assign data_valid   = !fifo_empty;
  assign frame_active = frame_active_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// Randomized bench for bit_deserializer: a bit-level reference model predicts the
// byte stream into a scoreboard queue; a monitor pops and compares on each handshake.
module tb_bit_deserializer;

  localparam int FifoDepth = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signal = 1'b0;
  logic [31:0] bit_period = 32'd20;
  logic        period_lock = 1'b0;
  logic        data_ready = 1'b0;
  logic [7:0]  data;
  logic        data_valid, frame_active, overflow;

  bit_deserializer #(
    .PERIOD_LEN(32),
    .SYNC_WORD (8'hD5),
    .MIN_PERIOD(8),
    .IDLE_BITS (16),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .signal      (signal),
    .bit_period  (bit_period),
    .period_lock (period_lock),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_active(frame_active),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  logic       stim[$];
  bit         rand_ready = 1'b0;

  // Reference model state: bits seen at the strobe rate, not cycle timing.
  bit         m_in_data;
  logic [7:0] m_shift;
  int         m_cnt;
  int         m_run;
  logic       m_prev;
  bit         m_bp = 1'b0;
  bit         m_overflow = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void emit(input logic [7:0] v);
    if (m_bp && exp_q.size() >= FifoDepth) m_overflow = 1'b1;
    else exp_q.push_back(v);
  endfunction

  function automatic void model_run();
    foreach (stim[i]) begin
      logic b;
      b = stim[i];
      m_run  = (b != m_prev) ? 1 : ((m_run < 16) ? m_run + 1 : 16);
      m_prev = b;
      m_shift = {m_shift[6:0], b};
      if (!m_in_data) begin
        if (m_shift == 8'hD5) begin
          m_in_data = 1'b1;
          m_cnt     = 0;
        end
      end else begin
        m_cnt++;
        if (m_cnt == 8) begin
          m_cnt = 0;
          emit(m_shift);
        end
        if (m_run == 16) begin
          m_in_data = 1'b0;
          m_shift   = '0;
          m_cnt     = 0;
        end
      end
    end
  endfunction

  function automatic void add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
  endfunction

  function automatic void add_hold(input int n);
    logic v;
    v = (stim.size() > 0) ? stim[stim.size()-1] : 1'b0;
    for (int i = 0; i < n; i++) stim.push_back(v);
  endfunction

  // All tasks start and end at posedge+1.
  task automatic play(input int p);
    model_run();
    foreach (stim[i]) begin
      signal = stim[i];
      repeat (p) @(posedge clk);
      #1;
    end
    stim.delete();
  endtask

  task automatic prep(input int p);
    period_lock = 1'b0;
    signal      = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    bit_period  = p;
    period_lock = 1'b1;
    repeat (3 * p) @(posedge clk);
    #1;
    m_in_data = 1'b0;
    m_shift   = '0;
    m_cnt     = 0;
    m_run     = 0;
    m_prev    = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) data_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h expected none", data);
      end else begin
        check("byte", data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       saw_active;
    int         p, nb;
    logic [7:0] b;

    #1;
    check("rst_data", data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_frame", frame_active, 0);
    check("rst_ovf", overflow, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Nominal frame, ended by lock loss so only the payload byte is produced.
    rand_ready = 1'b1;
    prep(20);
    add_byte(8'hD5);
    play(20);
    check("nom_frame_after_sync", frame_active, 1);
    add_byte(8'h3C);
    play(20);
    drain("nom_drain");
    check("nom_ovf", overflow, 0);

    // False sync.
    prep(20);
    add_byte(8'hD4);
    play(20);
    check("false_frame1", frame_active, 0);
    add_byte(8'h3C);
    play(20);
    check("false_frame2", frame_active, 0);
    drain("false_drain");

    // Idle timeout after a few data bits.
    prep(20);
    add_byte(8'hD5);
    play(20);
    check("to_frame_sync", frame_active, 1);
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1); stim.push_back(1'b1);
    add_hold(20);
    play(20);
    check("to_frame_fall", frame_active, 0);
    drain("to_drain");

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      p = $urandom_range(8, 30);
      prep(p);
      add_byte(($urandom_range(0, 3) == 0) ? 8'hD4 : 8'hD5);
      nb = $urandom_range(1, 5);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom_range(0, 255));
        add_byte(b);
      end
      for (int k = $urandom_range(0, 7); k > 0; k--) stim.push_back(1'($urandom_range(0, 1)));
      add_hold(20);
      play(p);
      drain("rnd_drain");
      check("rnd_frame", frame_active, m_in_data);
      check("rnd_ovf", overflow, m_overflow);
    end

    // Lock loss mid-byte, then a too-short period.
    prep(16);
    add_byte(8'hD5);
    add_byte(8'hA7);
    stim.push_back(1'b1); stim.push_back(1'b1); stim.push_back(1'b0);
    play(16);
    check("lock_frame_before", frame_active, 1);
    period_lock = 1'b0;
    @(posedge clk);
    #1;
    check("lock_frame_after", frame_active, 0);
    drain("lock_drain");
    signal      = 1'b0;
    bit_period  = 6;
    period_lock = 1'b1;
    saw_active  = 1'b0;
    add_byte(8'hD5);
    add_byte(8'h3C);
    foreach (stim[i]) begin
      signal = stim[i];
      for (int c = 0; c < 6; c++) begin
        @(posedge clk);
        #1;
        saw_active = saw_active | frame_active;
      end
    end
    stim.delete();
    repeat (20) @(posedge clk);
    #1;
    check("short_no_frame", saw_active, 0);
    check("short_no_data", data_valid, 0);

    // Backpressure: only the first FifoDepth bytes survive.
    rand_ready = 1'b0;
    data_ready = 1'b0;
    prep(20);
    m_bp = 1'b1;
    add_byte(8'hD5);
    for (int k = 1; k <= 5; k++) add_byte(8'(k));
    play(20);
    repeat (4) @(posedge clk);
    #1;
    check("bp_ovf", overflow, m_overflow);
    check("bp_valid", data_valid, 1);
    check("bp_head", data, exp_q[0]);
    period_lock = 1'b0;
    m_bp        = 1'b0;
    rand_ready  = 1'b1;
    drain("bp_drain");
    check("bp_ovf_sticky", overflow, 1);

    // Reset mid-frame with bytes held in the FIFO.
    rand_ready = 1'b0;
    data_ready = 1'b0;
    prep(20);
    add_byte(8'hD5);
    add_byte(8'h5A);
    add_byte(8'hC3);
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
    play(20);
    check("rmf_valid", data_valid, 1);
    check("rmf_head", data, exp_q[0]);
    check("rmf_frame", frame_active, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmf_data0", data, 0);
    check("rmf_valid0", data_valid, 0);
    check("rmf_frame0", frame_active, 0);
    check("rmf_ovf0", overflow, 0);
    exp_q.delete();
    m_overflow = 1'b0;
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    rand_ready = 1'b1;
    prep(20);
    add_byte(8'hD5);
    add_byte(8'h96);
    play(20);
    check("post_rst_frame", frame_active, 1);
    period_lock = 1'b0;
    drain("post_rst_drain");
    check("post_rst_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
